// File: rtl/keypad_scanner.sv
// 4x4 matrix hex keypad scanner: walks the columns, debounces presses and
// releases, and emits exactly one key_in strobe per accepted keystroke.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_in,
    output logic [3:0] key_val,
    output logic       key_down
);
    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       DEB_N    = 8'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        if (!rows[0]) begin
            return 2'd0;
        end else if (!rows[1]) begin
            return 2'd1;
        end else if (!rows[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v >= DEB_N) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    logic [3:0]       row_meta_r, row_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       col_r, col_nxt_s;
    logic [3:0]       col_out_r;
    state_t           state_r, state_nxt_s;
    logic [3:0]       cand_r, cand_nxt_s;
    logic [7:0]       cnt_r, cnt_nxt_s, rel_r, rel_nxt_s;
    logic             key_in_r, key_down_r, down_nxt_s;
    logic [3:0]       key_val_r, val_nxt_s;
    logic             tick_s, pressed_s, accept_s, strobe_s;
    logic [3:0]       code_s;

    assign tick_s    = (div_r == DIV_LAST);
    assign pressed_s = ~&row_sync_r;
    assign code_s    = {first_low_row(row_sync_r), col_r};

    // Two-flop synchronizer for the asynchronous keypad rows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= row_in;
            row_sync_r <= row_meta_r;
        end
    end

    // Sample-tick divider.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Next-state logic; a column only advances when no key is being tracked.
    always_comb begin
        state_nxt_s = state_r;
        col_nxt_s   = col_r;
        cand_nxt_s  = cand_r;
        cnt_nxt_s   = cnt_r;
        rel_nxt_s   = rel_r;
        val_nxt_s   = key_val_r;
        down_nxt_s  = key_down_r;
        accept_s    = 1'b0;
        strobe_s    = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_SCAN: begin
                    if (pressed_s) begin
                        cand_nxt_s = code_s;
                        cnt_nxt_s  = 8'd1;
                        if (DEB_N == 8'd1) begin
                            accept_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_CONFIRM;
                        end
                    end else begin
                        col_nxt_s = col_r + 2'd1;
                    end
                end
                ST_CONFIRM: begin
                    if (pressed_s && (code_s == cand_r)) begin
                        cnt_nxt_s = sat_inc(cnt_r);
                        if (cnt_nxt_s == DEB_N) begin
                            accept_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_CONFIRM;
                        end
                    end else begin
                        state_nxt_s = ST_SCAN;
                        col_nxt_s   = col_r + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (pressed_s) begin
                        rel_nxt_s = 8'd0;
                    end else begin
                        rel_nxt_s = sat_inc(rel_r);
                        if (rel_nxt_s == DEB_N) begin
                            down_nxt_s  = 1'b0;
                            state_nxt_s = ST_SCAN;
                            col_nxt_s   = col_r + 2'd1;
                        end else begin
                            state_nxt_s = ST_HELD;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_SCAN;
                end
            endcase
        end else begin
            accept_s = 1'b0;
        end
        if (accept_s) begin
            strobe_s    = 1'b1;
            val_nxt_s   = code_s;
            down_nxt_s  = 1'b1;
            rel_nxt_s   = 8'd0;
            state_nxt_s = ST_HELD;
        end else begin
            strobe_s = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_SCAN;
            col_r      <= 2'd0;
            col_out_r  <= 4'b1110;
            cand_r     <= 4'h0;
            cnt_r      <= 8'd0;
            rel_r      <= 8'd0;
            key_in_r   <= 1'b0;
            key_val_r  <= 4'h0;
            key_down_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            col_r      <= col_nxt_s;
            col_out_r  <= ~(4'b0001 << col_nxt_s);
            cand_r     <= cand_nxt_s;
            cnt_r      <= cnt_nxt_s;
            rel_r      <= rel_nxt_s;
            key_in_r   <= strobe_s;
            key_val_r  <= val_nxt_s;
            key_down_r <= down_nxt_s;
        end
    end

    assign col_out  = col_out_r;
    assign key_in   = key_in_r;
    assign key_val  = key_val_r;
    assign key_down = key_down_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner with a tick-level keypad
// reference model and directed scenarios for bounce, rollover and reset.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic        clock;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_in;
    logic [3:0]  key_val;
    logic        key_down;
    logic [15:0] keys;  // keys[row*4+col] = 1 while that key is held

    int n_checks = 0;
    int n_pass = 0;
    int n_strobes = 0;
    int last_val = -1;
    int cyc = 0;
    int sb[$];

    // reference model variables
    int         m_div, m_col, m_phase, m_cand, m_agree, m_quiet;
    bit         m_down;
    logic [3:0] m_val, m_s1, m_s2, m_now;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out),
        .key_in(key_in), .key_val(key_val), .key_down(key_down)
    );

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [3:0] rows_for(input logic [15:0] k, input int c);
        logic [3:0] rows;
        for (int r = 0; r < 4; r++) rows[r] = ~k[r*4 + c];
        return rows;
    endfunction

    function automatic int lowest_zero(input logic [3:0] rows);
        for (int r = 0; r < 4; r++) if (!rows[r]) return r;
        return -1;
    endfunction

    task automatic model_init();
        m_div = 0; m_col = 0; m_phase = 0; m_cand = 0; m_agree = 0; m_quiet = 0;
        m_down = 1'b0; m_val = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF;
        sb.delete();
    endtask

    task automatic model_accept();
        m_val = 4'(m_cand);
        m_down = 1'b1;
        m_quiet = 0;
        m_phase = 2;
        sb.push_back(m_cand);
    endtask

    // Reference model: one evaluation per sample tick on the rows seen two edges earlier.
    initial begin
        int code;
        model_init();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_init();
            end else begin
                cyc++;
                m_now = rows_for(keys, m_col);
                if (m_div == SCAN_DIV - 1) begin
                    code = (m_s2 != 4'hF) ? lowest_zero(m_s2) * 4 + m_col : -1;
                    if (m_phase == 0) begin
                        if (code < 0) m_col = (m_col + 1) % 4;
                        else begin
                            m_cand = code; m_agree = 1; m_phase = 1;
                            if (m_agree >= DEBOUNCE) model_accept();
                        end
                    end else if (m_phase == 1) begin
                        if (code == m_cand) begin
                            m_agree = (m_agree < DEBOUNCE) ? m_agree + 1 : DEBOUNCE;
                            if (m_agree >= DEBOUNCE) model_accept();
                        end else begin
                            m_phase = 0; m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        if (code >= 0) m_quiet = 0;
                        else begin
                            m_quiet++;
                            if (m_quiet >= DEBOUNCE) begin
                                m_down = 1'b0; m_phase = 0; m_col = (m_col + 1) % 4;
                            end
                        end
                    end
                end
                m_s2 = m_s1;
                m_s1 = m_now;
                m_div = (m_div + 1) % SCAN_DIV;
            end
        end
    end

    // Monitor: per-cycle output checks and strobe scoreboard.
    initial begin
        logic [3:0] exp_col;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_col = 4'b0001 << m_col;
                exp_col = ~exp_col;
                chk("col_out", col_out, exp_col);
                chk("key_down", key_down, m_down);
                chk("key_val", key_val, m_val);
                if (key_in) begin
                    n_strobes++;
                    last_val = key_val;
                    if (sb.size() == 0) chk("unexpected strobe", 1, 0);
                    else chk("strobe code", key_val, sb.pop_front());
                end else if (sb.size() != 0) begin
                    chk("missed strobe", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_strobes(input int target, input int limit, input string name);
        int n = 0;
        while (n_strobes < target && n < limit) begin step(); n++; end
        chk(name, n_strobes >= target, 1);
    endtask

    task automatic wait_release(input string name);
        int n = 0;
        while (key_down && n < 100) begin step(); n++; end
        chk(name, key_down, 0);
    endtask

    task automatic pulse_reset(input string name);
        #2;
        reset = 1'b0;
        #1;
        chk({name, " col_out"}, col_out, 4'b1110);
        chk({name, " key_in"}, key_in, 0);
        chk({name, " key_val"}, key_val, 0);
        chk({name, " key_down"}, key_down, 0);
        keys = 16'h0;
        repeat (3) begin step(); chk({name, " key_in low"}, key_in, 0); end
        reset = 1'b1;
        repeat (2) begin step(); chk({name, " key_in after"}, key_in, 0); end
    endtask

    initial begin
        logic [3:0] exp_col;
        int s0, n;
        reset = 1'b0;
        keys = 16'h0;
        repeat (3) step();
        chk("reset col_out", col_out, 4'b1110);
        chk("reset key_in", key_in, 0);
        chk("reset key_val", key_val, 0);
        chk("reset key_down", key_down, 0);
        reset = 1'b1;

        // idle column walk
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_col = 4'b0001 << ((k / 4) % 4);
            exp_col = ~exp_col;
            chk("idle col walk", col_out, exp_col);
            chk("idle key_in", key_in, 0);
        end

        // steady press (2,1)
        s0 = n_strobes;
        keys[9] = 1'b1;
        repeat (200) step();
        chk("steady one strobe", n_strobes - s0, 1);
        chk("steady code", last_val, 9);
        chk("steady key_down", key_down, 1);
        keys = 16'h0;
        wait_release("steady release");

        // bounce on (1,3): two agreeing ticks only
        n = 0;
        while (col_out != 4'b0111 && n < 40) begin step(); n++; end
        chk("bounce reach col3", col_out, 4'b0111);
        s0 = n_strobes;
        keys[7] = 1'b1;
        repeat (8) step();
        keys = 16'h0;
        n = 0;
        while (col_out == 4'b0111 && n < 12) begin step(); n++; end
        chk("bounce resumes col0", col_out, 4'b1110);
        chk("bounce no strobe", n_strobes - s0, 0);

        // two strokes (0,0) then (3,3)
        s0 = n_strobes;
        keys[0] = 1'b1;
        wait_strobes(s0 + 1, 100, "stroke1 strobe");
        chk("stroke1 code", last_val, 0);
        repeat (10) step();
        keys = 16'h0;
        wait_release("stroke1 release");
        repeat (40) step();
        chk("key_val held", key_val, 4'h0);
        keys[15] = 1'b1;
        wait_strobes(s0 + 2, 100, "stroke2 strobe");
        chk("stroke2 code", last_val, 15);
        keys = 16'h0;
        wait_release("stroke2 release");

        // simultaneous (0,2) and (3,2)
        s0 = n_strobes;
        keys[2] = 1'b1;
        keys[14] = 1'b1;
        repeat (100) step();
        chk("simul one strobe", n_strobes - s0, 1);
        chk("simul code", last_val, 2);
        keys[2] = 1'b0;
        repeat (60) step();
        chk("simul still down", key_down, 1);
        chk("simul no new strobe", n_strobes - s0, 1);
        keys = 16'h0;
        wait_release("simul release");

        // reset mid-HELD
        keys[5] = 1'b1;
        wait_strobes(n_strobes + 1, 100, "held strobe");
        repeat (5) step();
        pulse_reset("rst held");
        // reset mid-CONFIRM
        keys[6] = 1'b1;
        n = 0;
        while (m_phase != 1 && n < 100) begin step(); n++; end
        chk("reach confirm", m_phase, 1);
        pulse_reset("rst confirm");
        s0 = n_strobes;
        keys[10] = 1'b1;
        wait_strobes(s0 + 1, 100, "post-reset strobe");
        chk("post-reset code", last_val, 10);
        keys = 16'h0;
        wait_release("post-reset release");

        // randomized presses, bounces and rollovers against the model
        for (int it = 0; it < 40; it++) begin
            keys[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
            n = $urandom_range(1, 80);
            for (int c = 0; c < n; c++) begin
                step();
                if ($urandom_range(0, 15) == 0) keys = keys ^ (16'h1 << $urandom_range(0, 15));
            end
            keys = 16'h0;
            repeat ($urandom_range(5, 80)) step();
        end
        repeat (100) step();
        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix hex keypad, debounces each press and emits a one-cycle strobe with a 4-bit key code. It sits directly upstream of the 32-bit key shift buffer: its `key_in`/`key_val` outputs drive that buffer's `key_in`/`key_val` inputs unchanged. The buffer shifts in `key_val` on any cycle where `key_in` is 1, so the scanner guarantees exactly one strobe per physical press.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before its rows are sampled. Legal range ≥4.
- `DEBOUNCE`, default 8: number of consecutive agreeing samples needed to accept a press or a release. Legal range 1..255.

- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `row_in` in 4: keypad rows, active-low, externally pulled high, asynchronous to `clock`.
- `col_out` out 4: column drive, active-low, exactly one bit low at all times.
- `key_in` out 1: one-cycle strobe for an accepted press.
- `key_val` out 4: code of the last accepted key, defined as row*4 + col. Valid in the strobe cycle and held until the next strobe.
- `key_down` out 1: 1 from the strobe cycle until the release is accepted.

## Operation
- `row_in` passes through a 2-flop synchronizer before any use.
- Divider `div` counts 0..SCAN_DIV-1 and wraps. A sample tick occurs in each cycle where `div == SCAN_DIV-1`. Only the synchronized rows present in that tick cycle are evaluated.
- Column index `col` (2 bits) drives `col_out = ~(4'b0001 << col)`. `col` advances (3 wraps to 0) only on a tick while in SCAN, or on the tick that leaves CONFIRM or HELD for SCAN. In every other case it is frozen.
- A sample is "pressed" if any synchronized row bit is 0. The code is {row, col}, using the lowest-index low row.
- State machine:
  - SCAN. Tick with no press: advance `col`. Tick with a press: latch the candidate code, set `cnt`=1, go to CONFIRM with `col` frozen. If DEBOUNCE=1, accept immediately (see CONFIRM).
  - CONFIRM. Tick where the sample matches the candidate: `cnt`+1. When `cnt` reaches DEBOUNCE, accept: `key_in`=1 for the next cycle only, `key_val` gets the candidate, `key_down`=1, `rel`=0, go to HELD. Tick with no press or a different code: go to SCAN and advance `col`, with no strobe.
  - HELD. Tick with no press: `rel`+1. When `rel` reaches DEBOUNCE, set `key_down`=0, go to SCAN and advance `col`. Tick with any press (any row, including a different one): `rel`=0. No strobe in HELD.
- Only one key is reported at a time. Keys in other columns are ignored while CONFIRM or HELD has `col` frozen.
- `cnt` and `rel` saturate at DEBOUNCE and never wrap.

## Timing
- Reset values: `col_out`=4'b1110, `key_in`=0, `key_val`=4'h0, `key_down`=0. State is SCAN; `div`, `cnt` and `rel` are 0; synchronizer flops are 4'b1111.
- `key_in`, `key_val` and `key_down` are registered and driven by no combinational paths.
- Strobe latency: `key_in` rises on the clock edge that ends the tick cycle of the DEBOUNCE-th agreeing sample.
  - Minimum time from a stable press to the strobe is 2 sync cycles plus DEBOUNCE ticks.
  - Worst case adds up to one full scan of 4*SCAN_DIV cycles.
- Settling: after a column change there are SCAN_DIV-1 cycles before the next sample, which is at least 3 and covers synchronizer delay.
- `key_in` is never high two cycles in a row. At least DEBOUNCE*SCAN_DIV cycles separate two strobes.
- Reset low during any state: all outputs take their reset values asynchronously. A pending strobe is dropped.
- `reset` deassertion: scanning starts on the first clock edge with `col`=0 and `div`=0.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=3. Keypad model: `row_in[r]` = 0 iff key (r,c) is pressed and `col_out[c]`=0, else 1.
- Idle after reset: `col_out` steps 1110→1101→1011→0111→1110, every 4 cycles. `key_in`, `key_down` and `key_val` stay 0.
- Steady press of (row2, col1) for 200 cycles: exactly one `key_in` pulse with `key_val`=4'h9. `key_down`=1 from the strobe until 3 no-press ticks after release.
- Bounce: (row1, col3) pressed for only 2 ticks of col 3, then released: no strobe. Scanning resumes at col 0.
- Two strokes: press (0,0), release 40 cycles, press (3,3): strobes with `key_val` 4'h0 then 4'hF. `key_val` holds 4'h0 between the two strobes.
- Simultaneous (row0, col2) and (row3, col2): `key_val`=4'h2, one strobe. Releasing row0 alone keeps `key_down`=1 with no new strobe.
- Reset pulsed low mid-HELD and mid-CONFIRM: outputs go to reset values asynchronously, with no `key_in` pulse around the reset. After release a fresh press strobes normally.
